// File: rtl/uart_rx_packer.sv
// uart_rx_packer: oversampled UART receiver with majority voting, optional
// parity, false-start rejection and sticky error flags. Accepted characters
// are packed NUM_WORDS at a time into one wide word and delivered on a
// valid/ready interface.
module uart_rx_packer #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned NUM_WORDS   = 20,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clken,
   input  logic                           rx,
   output logic [DATA_BITS*NUM_WORDS-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           frame_err,
   output logic                           parity_err,
   output logic                           overrun,
   input  logic                           err_clr
);

   localparam int unsigned WORD_W = DATA_BITS * NUM_WORDS;
   localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 state_q;
   logic                   rx_meta_q;
   logic                   rx_s_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [BIT_W-1:0]       bit_q;
   logic [1:0]             samp_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_q;
   logic [WORD_W-1:0]      pack_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   done_q;
   logic                   frame_err_q;
   logic                   parity_err_q;
   logic [WORD_W-1:0]      out_data_q;
   logic                   out_valid_q;
   logic                   overrun_q;

   logic                   maj_bit;
   logic                   par_xor;
   logic                   parity_bad;

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Majority of the three mid-bit samples and the parity verdict.
   always_comb begin
      maj_bit    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
      par_xor    = (^shift_q) ^ par_q;
      parity_bad = 1'b0;
      if (PARITY_MODE == 1) begin
         parity_bad = par_xor;
      end else if (PARITY_MODE == 2) begin
         parity_bad = ~par_xor;
      end
   end

   // Receive FSM, sample counter, character packing and line error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         samp_q       <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         pack_q       <= '0;
         idx_q        <= '0;
         done_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Clear first so that a set event later in this block wins.
         if (err_clr) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
         end
         if (clken) begin
            if (cnt_q == CNT_PRE) begin
               samp_q[0] <= rx_s_q;
            end
            if (cnt_q == CNT_MID) begin
               samp_q[1] <= rx_s_q;
            end
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
               S_IDLE: begin
                  // Counter is pinned at 0 here, so the start bit begins counting fresh.
                  cnt_q <= '0;
                  if (!rx_s_q) begin
                     state_q <= S_START;
                  end
               end
               S_START: begin
                  if (cnt_q == CNT_POST && maj_bit) begin
                     state_q <= S_IDLE;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= S_DATA;
                     bit_q   <= '0;
                  end
               end
               S_DATA: begin
                  if (cnt_q == CNT_POST) begin
                     shift_q <= {maj_bit, shift_q[DATA_BITS-1:1]};
                  end
                  if (cnt_q == CNT_LAST) begin
                     if (bit_q == BIT_LAST) begin
                        state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end
               end
               S_PARITY: begin
                  if (cnt_q == CNT_POST) begin
                     par_q <= maj_bit;
                  end
                  if (cnt_q == CNT_LAST) begin
                     state_q <= S_STOP;
                  end
               end
               S_STOP: begin
                  // Decided mid-bit: IDLE is re-entered early so a back-to-back
                  // start edge is not missed.
                  if (cnt_q == CNT_POST) begin
                     if (!maj_bit) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_BREAK;
                     end else if (parity_bad) begin
                        parity_err_q <= 1'b1;
                        state_q      <= S_IDLE;
                     end else begin
                        pack_q[idx_q*DATA_BITS +: DATA_BITS] <= shift_q;
                        if (idx_q == IDX_LAST) begin
                           idx_q  <= '0;
                           done_q <= 1'b1;
                        end else begin
                           idx_q <= idx_q + 1'b1;
                        end
                        state_q <= S_IDLE;
                     end
                  end
               end
               S_BREAK: begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Output word register, valid/ready handshake and overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (err_clr) begin
            overrun_q <= 1'b0;
         end
         if (done_q) begin
            // A completion in a transfer cycle replaces the word without loss.
            if (out_valid_q && !out_ready) begin
               overrun_q <= 1'b1;
            end else begin
               out_data_q  <= pack_q;
               out_valid_q <= 1'b1;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: three instances cover the default
// 8N1 x20 packing, even parity x2 and a single-character word.
module tb_uart_rx_packer;

   logic         clk = 1'b0;
   logic         clken = 1'b0;
   logic         rst_n;
   logic [2:0]   rx_v;
   logic [2:0]   rdy_v;
   logic [2:0]   clr_v;

   logic [159:0] d0;
   logic [15:0]  d1;
   logic [7:0]   d2;
   logic         v0, v1, v2;
   logic         fe0, fe1, fe2;
   logic         pe0, pe1, pe2;
   logic         ov0, ov1, ov2;

   int           total = 0;
   int           bad = 0;
   int           n0 = 0, n1 = 0, n2 = 0;
   logic [159:0] last0 = '0;
   logic [15:0]  last1 = '0;
   logic [7:0]   last2 = '0;
   logic [159:0] exp_w;

   uart_rx_packer u0 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .rx(rx_v[0]),
      .out_data(d0), .out_valid(v0), .out_ready(rdy_v[0]),
      .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .err_clr(clr_v[0])
   );

   uart_rx_packer #(.PARITY_MODE(1), .NUM_WORDS(2)) u1 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .rx(rx_v[1]),
      .out_data(d1), .out_valid(v1), .out_ready(rdy_v[1]),
      .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .err_clr(clr_v[1])
   );

   uart_rx_packer #(.NUM_WORDS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .clken(clken), .rx(rx_v[2]),
      .out_data(d2), .out_valid(v2), .out_ready(rdy_v[2]),
      .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .err_clr(clr_v[2])
   );

   always #5 clk = ~clk;

   // Baud tick: one clock high, one clock low.
   always @(negedge clk) clken = ~clken;

   // Handshake monitor, sampled at the falling edge.
   always @(negedge clk) begin
      if (v0 && rdy_v[0]) begin n0++; last0 = d0; end
      if (v1 && rdy_v[1]) begin n1++; last1 = d1; end
      if (v2 && rdy_v[2]) begin n2++; last2 = d2; end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      @(posedge clk);
      while (clken !== 1'b1) @(posedge clk);
   endtask

   task automatic hold(input int unsigned sel, input logic v, input int unsigned n);
      rx_v[sel] = v;
      repeat (n) wait_tick();
      #1;
   endtask

   task automatic send(input int unsigned sel, input logic [8:0] d, input bit has_par,
                       input logic par, input bit glitch);
      hold(sel, 1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (glitch) begin
            hold(sel, d[i], 9);
            hold(sel, ~d[i], 1);
            hold(sel, d[i], 6);
         end else begin
            hold(sel, d[i], 16);
         end
      end
      if (has_par) hold(sel, par, 16);
      hold(sel, 1'b1, 16);
      hold(sel, 1'b1, 4);
   endtask

   task automatic pulse_clr(input int unsigned sel);
      clr_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      clr_v[sel] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rx_v  = 3'b111;
      rdy_v = 3'b011;
      clr_v = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      check("rst_data0", d0, 160'h0);
      check("rst_valid0", v0, 1'b0);
      check("rst_fe0", fe0, 1'b0);
      check("rst_pe0", pe0, 1'b0);
      check("rst_ov0", ov0, 1'b0);
      check("rst_valid1", v1, 1'b0);
      check("rst_valid2", v2, 1'b0);
      rst_n = 1'b1;
      hold(0, 1'b1, 4);

      // 20 characters 0x00..0x13, 8N1, ready high.
      for (int i = 0; i < 20; i++) send(0, 9'(i), 1'b0, 1'b0, 1'b0);
      exp_w = '0;
      for (int i = 0; i < 20; i++) exp_w[8*i +: 8] = 8'(i);
      check("t1_xfers", n0, 1);
      check("t1_word", last0, exp_w);
      check("t1_byte0", last0[7:0], 8'h00);
      check("t1_byte19", last0[159:152], 8'h13);
      check("t1_valid_drop", v0, 1'b0);
      check("t1_flags", {fe0, pe0, ov0}, 3'b000);

      // Stop bit low, then the line held low for three bit times.
      hold(0, 1'b0, 16);
      for (int i = 0; i < 8; i++) hold(0, (i % 2 == 0) ? 1'b1 : 1'b0, 16);
      hold(0, 1'b0, 16);
      check("t4_frame_set", fe0, 1'b1);
      pulse_clr(0);
      hold(0, 1'b0, 48);
      check("t4_single_frame", fe0, 1'b0);
      hold(0, 1'b1, 8);

      // Five-tick false start in IDLE.
      hold(0, 1'b0, 5);
      hold(0, 1'b1, 30);
      check("t2_flags", {fe0, pe0, ov0}, 3'b000);
      check("t2_no_xfer", n0, 1);
      for (int i = 0; i < 20; i++) send(0, 9'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      check("t2_xfers", n0, 2);
      check("t2_slot0", last0[7:0], 8'h40);
      check("t2_slot19", last0[159:152], 8'h53);

      // Even parity, 2-word packing: 0xA5 with a wrong parity bit of 1.
      send(1, 9'h0A5, 1'b1, 1'b1, 1'b0);
      check("t3_parity_set", pe1, 1'b1);
      check("t3_no_frame", fe1, 1'b0);
      pulse_clr(1);
      check("t3_parity_clr", pe1, 1'b0);
      send(1, 9'h05A, 1'b1, 1'b0, 1'b0);
      send(1, 9'h03C, 1'b1, 1'b0, 1'b0);
      check("t3_xfers", n1, 1);
      check("t3_word", last1, 16'h3C5A);
      check("t3_parity_ok", pe1, 1'b0);

      // Single-character word with the consumer stalled.
      send(2, 9'h011, 1'b0, 1'b0, 1'b0);
      check("t5_valid", v2, 1'b1);
      check("t5_data", d2, 8'h11);
      check("t5_no_overrun", ov2, 1'b0);
      send(2, 9'h022, 1'b0, 1'b0, 1'b0);
      check("t5_overrun", ov2, 1'b1);
      check("t5_data_held", d2, 8'h11);
      check("t5_valid_held", v2, 1'b1);
      rdy_v[2] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t5_xfers", n2, 1);
      check("t5_xfer_data", last2, 8'h11);
      check("t5_valid_drop", v2, 1'b0);

      // Mid-bit glitches on every data bit of 0x3C.
      send(2, 9'h03C, 1'b0, 1'b0, 1'b1);
      check("t6_xfers", n2, 2);
      check("t6_voted", last2, 8'h3C);
      check("t6_no_frame", fe2, 1'b0);

      // Reset asserted partway through a character.
      hold(2, 1'b0, 16);
      hold(2, 1'b1, 20);
      rst_n = 1'b0;
      #2;
      check("t6_rst_data0", d0, 160'h0);
      check("t6_rst_valid0", v0, 1'b0);
      check("t6_rst_data2", d2, 8'h00);
      check("t6_rst_valid2", v2, 1'b0);
      check("t6_rst_ov2", ov2, 1'b0);
      check("t6_rst_flags2", {fe2, pe2}, 2'b00);
      rx_v = 3'b111;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold(2, 1'b1, 4);
      send(2, 9'h077, 1'b0, 1'b0, 1'b0);
      check("t6_after_rst_xfers", n2, 3);
      check("t6_after_rst_data", last2, 8'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
